// File: rtl/ag6502_mem_bridge.sv
// rtl/ag6502_mem_bridge.sv - 6502 bus responder bridging to a req/ack memory port
// Posts CPU writes through a small FIFO, stalls reads with rdy and serves repeats from a one-entry hold register.
module ag6502_mem_bridge #(
  parameter int WDEPTH = 4
) (
  input  logic        phi_0,
  input  logic        rst,
  input  logic        phi_2,
  input  logic [15:0] ab,
  input  logic        read,
  input  logic [7:0]  db_out,
  output logic [7:0]  db_in,
  output logic        rdy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        wr_ovf
);
  localparam int AW = $clog2(WDEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(WDEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, RD_REQ, RD_DONE} state_t;
  state_t state;

  logic          phi2_q;
  logic [15:0]   fifo_addr [WDEPTH];
  logic [7:0]    fifo_data [WDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   pend_addr, hold_addr;
  logic [7:0]    hold_data;
  logic          hold_v, stale;

  logic stb, wr_stb, rd_stb, full, empty, push, ack_wr, ack_rd, hit, addr_chg, issue_wr;

  assign stb      = phi_2 & ~phi2_q;
  assign wr_stb   = stb & ~read;
  assign rd_stb   = stb & read;
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign push     = wr_stb & ~full;
  assign ack_wr   = mem_req & mem_ack & mem_we;
  assign ack_rd   = mem_req & mem_ack & ~mem_we;
  assign hit      = hold_v & (ab == hold_addr);
  assign addr_chg = (ab != pend_addr);
  // Writes stay parked while a read is on the bus so the read is never held up behind them.
  assign issue_wr = ~mem_req & ~empty & (state != RD_REQ);

  always_ff @(posedge phi_0) begin
    if (rst && push) begin
      fifo_addr[wr_ptr] <= ab;
      fifo_data[wr_ptr] <= db_out;
    end
  end

  always_ff @(posedge phi_0) begin
    if (!rst) begin
      state     <= IDLE;
      phi2_q    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pend_addr <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      hold_v    <= 1'b0;
      stale     <= 1'b0;
      db_in     <= '0;
      rdy       <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ovf    <= 1'b0;
    end else begin
      phi2_q <= phi_2;

      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (ack_wr) rd_ptr <= rd_ptr + AW'(1);
      if (push && !ack_wr)      count <= count + (AW+1)'(1);
      else if (!push && ack_wr) count <= count - (AW+1)'(1);
      if (wr_stb && full) wr_ovf <= 1'b1;

      if (mem_req && mem_ack) mem_req <= 1'b0;
      if (issue_wr) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
      end

      case (state)
        IDLE, RD_DONE: begin
          if (rd_stb) begin
            if (hit) begin
              db_in <= hold_data;
              rdy   <= 1'b1;
              state <= IDLE;
            end else begin
              pend_addr <= ab;
              hold_v    <= 1'b0;
              rdy       <= 1'b0;
              if (!empty) begin
                state <= DRAIN;
              end else begin
                state    <= RD_REQ;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= ab;
              end
            end
          end
        end
        DRAIN: begin
          if (rd_stb) pend_addr <= ab;
          if (empty && !mem_req) state <= RD_REQ;
        end
        RD_REQ: begin
          if (ack_rd) begin
            // A newer address was presented while this fetch was in flight: drop its data and refetch.
            if (stale || (rd_stb && addr_chg)) begin
              stale <= 1'b0;
              if (rd_stb) pend_addr <= ab;
              state <= (!empty || push) ? DRAIN : RD_REQ;
            end else begin
              hold_data <= mem_rdata;
              hold_addr <= pend_addr;
              hold_v    <= 1'b1;
              rdy       <= 1'b1;
              state     <= RD_DONE;
            end
          end else if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rd_stb ? ab : pend_addr;
            if (rd_stb) pend_addr <= ab;
          end else if (rd_stb && addr_chg) begin
            stale     <= 1'b1;
            pend_addr <= ab;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_stb && ((ab == hold_addr) || (state == RD_REQ && ab == pend_addr)))
        hold_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ag6502_mem_bridge.sv
// tb/tb_ag6502_mem_bridge.sv - scoreboard bench for ag6502_mem_bridge
module tb_ag6502_mem_bridge;
  logic        phi_0, rst, phi_2, read, rdy, mem_req, mem_we, mem_ack, wr_ovf;
  logic [15:0] ab, mem_addr;
  logic [7:0]  db_out, db_in, mem_wdata, mem_rdata;

  ag6502_mem_bridge #(.WDEPTH(4)) dut (
    .phi_0(phi_0), .rst(rst), .phi_2(phi_2), .ab(ab), .read(read), .db_out(db_out),
    .db_in(db_in), .rdy(rdy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wr_ovf(wr_ovf)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } req_t;

  req_t       exp_req [$];
  logic [7:0] exp_db [$];
  logic [7:0] mem_m [0:65535];
  int errors = 0;
  int checks = 0;
  int mem_delay, wait_cnt, last_req_cycles;
  logic ack_en, late_ack;

  initial phi_0 = 1'b0;
  always #5 phi_0 = ~phi_0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic note_fail(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing", nm, act);
  endtask

  task automatic push_req(input logic we, input logic [15:0] a, input logic [7:0] d);
    req_t r;
    r = {we, a, d};
    exp_req.push_back(r);
  endtask

  task automatic bus_cycle(input logic rd, input logic [15:0] a, input logic [7:0] d, output logic stalled);
    @(negedge phi_0);
    ab = a; read = rd; db_out = d; phi_2 = 1'b1;
    @(negedge phi_0);
    stalled = ~rdy;
    @(negedge phi_0);
    phi_2 = 1'b0;
    repeat (2) @(negedge phi_0);
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!rdy && n < 1000) begin
      @(negedge phi_0);
      n++;
    end
    if (!rdy) note_fail("rdy_timeout", {31'b0, rdy});
  endtask

  task automatic wait_idle();
    int n = 0;
    int quiet = 0;
    while (quiet < 6 && n < 2000) begin
      @(negedge phi_0);
      n++;
      quiet = mem_req ? 0 : quiet + 1;
    end
    if (quiet < 6) note_fail("idle_timeout", {31'b0, mem_req});
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic accepted);
    logic st;
    if (accepted) push_req(1'b1, a, d);
    bus_cycle(1'b0, a, d, st);
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, output logic stalled);
    logic st2;
    exp_db.push_back(exp);
    bus_cycle(1'b1, a, 8'h00, stalled);
    if (stalled) begin
      wait_rdy();
      bus_cycle(1'b1, a, 8'h00, st2);
      check("represent_hit", {31'b0, st2}, 32'd0);
    end
  endtask

  // Memory responder: ack after mem_delay extra cycles of an asserted request.
  initial begin
    mem_ack = 1'b0; mem_rdata = 8'h00; wait_cnt = 0;
    forever begin
      @(posedge phi_0);
      #2;
      if (late_ack) begin
        mem_ack = 1'b1; late_ack = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0; wait_cnt = 0;
      end else if (mem_req && ack_en) begin
        if (wait_cnt == mem_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem_m[mem_addr] = mem_wdata;
          else mem_rdata = mem_m[mem_addr];
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Request monitor: every acknowledged transaction is matched against the expected queue.
  initial begin
    logic req_active;
    logic [24:0] snap;
    int req_cycles;
    req_t e;
    req_active = 1'b0; snap = '0; req_cycles = 0; last_req_cycles = 0;
    forever begin
      @(negedge phi_0);
      if (!mem_req) begin
        req_active = 1'b0;
      end else begin
        if (!req_active) begin
          req_active = 1'b1;
          snap = {mem_we, mem_addr, mem_wdata};
          req_cycles = 1;
        end else begin
          req_cycles++;
        end
        if (mem_ack) begin
          check("req_stable", {7'b0, mem_we, mem_addr, mem_wdata}, {7'b0, snap});
          last_req_cycles = req_cycles;
          if (!mem_we) check("rdy_low_at_rd_ack", {31'b0, rdy}, 32'd0);
          if (exp_req.size() == 0) begin
            note_fail("req_unexpected", {15'b0, mem_we, mem_addr});
          end else begin
            e = exp_req.pop_front();
            check("req_we", {31'b0, mem_we}, {31'b0, e.we});
            check("req_addr", {16'b0, mem_addr}, {16'b0, e.addr});
            if (e.we) check("req_wdata", {24'b0, mem_wdata}, {24'b0, e.data});
          end
          req_active = 1'b0;
        end
      end
    end
  end

  // Read-data monitor: a read strobe followed by rdy=1 means db_in was presented.
  initial begin
    logic p2q, stb_b, rd_b;
    logic [7:0] e;
    p2q = 1'b0;
    forever begin
      @(posedge phi_0);
      stb_b = phi_2 & ~p2q & rst;
      rd_b = read;
      p2q = rst ? phi_2 : 1'b0;
      if (stb_b && rd_b) begin
        @(negedge phi_0);
        if (rdy) begin
          if (exp_db.size() == 0) begin
            note_fail("db_unexpected", {24'b0, db_in});
          end else begin
            e = exp_db.pop_front();
            check("db_in", {24'b0, db_in}, {24'b0, e});
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic st, ok;
    rst = 1'b0; phi_2 = 1'b0; ab = 16'h0; read = 1'b1; db_out = 8'h0;
    ack_en = 1'b1; late_ack = 1'b0; mem_delay = 1;
    mem_m[16'h2000] = 8'h77; mem_m[16'h2100] = 8'h21;
    mem_m[16'h3000] = 8'h33; mem_m[16'h4000] = 8'h44;

    repeat (3) @(negedge phi_0);
    check("rst_db_in", {24'b0, db_in}, 32'h0);
    check("rst_rdy", {31'b0, rdy}, 32'd1);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", {16'b0, mem_addr}, 32'h0);
    check("rst_mem_wdata", {24'b0, mem_wdata}, 32'h0);
    check("rst_wr_ovf", {31'b0, wr_ovf}, 32'd0);
    rst = 1'b1;

    // Write then read back the same address through memory.
    cpu_write(16'h1234, 8'h5A, 1'b1);
    push_req(1'b0, 16'h1234, 8'h00);
    cpu_read(16'h1234, 8'h5A, st);
    check("t1_stall", {31'b0, st}, 32'd1);

    // Three-cycle memory latency, then a repeated read served from the hold register.
    mem_delay = 3;
    push_req(1'b0, 16'h2000, 8'h00);
    cpu_read(16'h2000, 8'h77, st);
    check("t2_stall", {31'b0, st}, 32'd1);
    check("t2_req_cycles", last_req_cycles, 32'd4);
    cpu_read(16'h2000, 8'h77, st);
    check("t2_repeat_hit", {31'b0, st}, 32'd0);
    mem_delay = 1;

    // Fill the FIFO with acks held off; the fifth write is dropped.
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) cpu_write(16'h6000 + 16'(i), 8'hA0 + 8'(i), 1'b1);
    check("t3_ovf_before", {31'b0, wr_ovf}, 32'd0);
    cpu_write(16'h6004, 8'hA4, 1'b0);
    @(negedge phi_0);
    check("t3_ovf_after", {31'b0, wr_ovf}, 32'd1);
    ack_en = 1'b1;
    wait_idle();

    // Two queued writes must drain before the read goes out.
    ack_en = 1'b0;
    cpu_write(16'h7000, 8'hB0, 1'b1);
    cpu_write(16'h7001, 8'hB1, 1'b1);
    push_req(1'b0, 16'h2100, 8'h00);
    exp_db.push_back(8'h21);
    bus_cycle(1'b1, 16'h2100, 8'h00, st);
    check("t4_stall", {31'b0, st}, 32'd1);
    ok = 1'b1;
    repeat (6) begin
      @(negedge phi_0);
      if (!(mem_req && mem_we && !rdy)) ok = 1'b0;
    end
    check("t4_drain_hold", {31'b0, ok}, 32'd1);
    ack_en = 1'b1;
    wait_rdy();
    bus_cycle(1'b1, 16'h2100, 8'h00, st);
    check("t4_represent_hit", {31'b0, st}, 32'd0);

    // Address switch while the read is in flight: the first fetch is discarded.
    mem_delay = 8;
    push_req(1'b0, 16'h3000, 8'h00);
    push_req(1'b0, 16'h4000, 8'h00);
    exp_db.push_back(8'h44);
    bus_cycle(1'b1, 16'h3000, 8'h00, st);
    check("t5_stall", {31'b0, st}, 32'd1);
    bus_cycle(1'b1, 16'h4000, 8'h00, st);
    check("t5_switch_stall", {31'b0, st}, 32'd1);
    wait_rdy();
    bus_cycle(1'b1, 16'h4000, 8'h00, st);
    check("t5_represent_hit", {31'b0, st}, 32'd0);
    mem_delay = 1;
    wait_idle();

    // Reset during an outstanding write request, then a late ack.
    ack_en = 1'b0;
    cpu_write(16'h8000, 8'hC0, 1'b1);
    begin
      int n = 0;
      while (!mem_req && n < 100) begin
        @(negedge phi_0);
        n++;
      end
    end
    check("t6_req_pending", {31'b0, mem_req}, 32'd1);
    rst = 1'b0;
    exp_req.delete();
    @(negedge phi_0);
    check("t6_mem_req", {31'b0, mem_req}, 32'd0);
    check("t6_rdy", {31'b0, rdy}, 32'd1);
    check("t6_db_in", {24'b0, db_in}, 32'h0);
    check("t6_wr_ovf", {31'b0, wr_ovf}, 32'd0);
    rst = 1'b1;
    ack_en = 1'b1;
    late_ack = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      @(negedge phi_0);
      if (mem_req) ok = 1'b0;
    end
    check("t6_no_req_after_reset", {31'b0, ok}, 32'd1);
    push_req(1'b0, 16'h2000, 8'h00);
    cpu_read(16'h2000, 8'h77, st);
    check("t6_hold_cleared", {31'b0, st}, 32'd1);
    wait_idle();

    check("exp_req_empty", exp_req.size(), 32'd0);
    check("exp_db_empty", exp_db.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ag6502_mem_bridge.md
# ag6502_mem_bridge

Bus responder that sits on the CPU side of the 6502-compatible bus (`ab`, `read`, `db_out` in; `db_in`, `rdy` out) and bridges it to a slower memory port with a request/acknowledge handshake. It posts CPU writes into a small FIFO. It stalls CPU reads with `rdy` until data returns. It keeps a one-entry read-hold register so a re-presented stalled read, or a repeated read of the same address, is served without a new memory access.

## Interface
Parameters:
- `WDEPTH`, default 4: write FIFO depth in entries (power of two, ≥2).

Ports:
- `phi_0`  in  1  single system clock; all state updates on its rising edge; must run ≥4× the `phi_2` rate.
- `rst`  in  1  reset, synchronous, active-low.
- `phi_2`  in  1  CPU bus phase, sampled as a level on `phi_0`.
- `ab`  in  16  CPU address.
- `read`  in  1  1 = read cycle, 0 = write cycle.
- `db_out`  in  8  CPU write data.
- `db_in`  out  8  read data to CPU (registered).
- `rdy`  out  1  0 = stall the CPU read.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write request.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  8  memory write data.
- `mem_rdata`  in  8  memory read data, valid while `mem_ack` = 1.
- `mem_ack`  in  1  one-cycle acknowledge of the current request.
- `wr_ovf`  out  1  sticky flag: a write was dropped because the FIFO was full.

## Operation
- Bus strobe: `stb = phi_2 & ~phi2_q`, where `phi2_q` is `phi_2` registered on `phi_0`. Each CPU bus cycle produces exactly one `stb`.
- Write strobe (`stb` & `!read`):
  - If the FIFO is not full, push {`ab`, `db_out`}.
  - If the FIFO is full, drop the write and set `wr_ovf`.
  - A write whose address equals `hold_addr` clears `hold_v`.
  - Writes are accepted in every FSM state.
- Read FSM states: IDLE, DRAIN, RD_REQ, RD_DONE. `rdy` = 1 in IDLE and RD_DONE, and 0 in DRAIN and RD_REQ.
  - Read strobe in IDLE or RD_DONE:
    - Hit (`hold_v` & `ab` == `hold_addr`): load `db_in` from the hold register and go to IDLE.
    - Miss: latch `ab` into `pend_addr`, clear `hold_v`, then go to DRAIN if the FIFO is non-empty, otherwise RD_REQ.
  - DRAIN: wait for the FIFO to empty, then go to RD_REQ. A read strobe here replaces `pend_addr`.
  - RD_REQ:
    - Assert `mem_req` = 1, `mem_we` = 0, `mem_addr` = `pend_addr`.
    - On `mem_ack`, capture `mem_rdata` into the hold register, set `hold_addr` = `pend_addr` and `hold_v` = 1, then go to RD_DONE.
    - A read strobe to a different address while in RD_REQ sets `stale` and updates `pend_addr`. On the ack, the data is discarded and the FSM goes to DRAIN (or RD_REQ) for the new address.
  - RD_DONE: data is ready and waits for the CPU to re-present the stalled read, which is then a hit.
- Memory arbitration:
  - One transaction is outstanding at a time.
  - Writes are issued only in IDLE, DRAIN and RD_DONE.
  - Write request: `mem_req` = 1, `mem_we` = 1, address and data from the FIFO head. Pop on `mem_ack`.
  - `mem_*` outputs stay stable from `mem_req` rise until the ack cycle.
- Ordering: a read never passes an older write, because misses always drain the FIFO first.
- Simultaneous push and pop in one cycle leaves the occupancy count unchanged. Pushing into a full FIFO is dropped even if a pop occurs in the same cycle.

## Timing
- Reset values, held while `rst` = 0:
  - `db_in` = 0, `rdy` = 1, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `wr_ovf` = 0.
  - FIFO empty, `hold_v` = 0, `stale` = 0, FSM = IDLE, `phi2_q` = 0.
- A reset mid-transaction abandons it. `mem_req` is low in the first cycle after reset, and a late `mem_ack` arriving after reset is ignored.
- `stb` is seen one `phi_0` cycle after `phi_2` rises.
- Outputs are registered: `db_in`, `rdy` and state update in the cycle after `stb`.
- Hit: `db_in` is valid 1 cycle after `stb`.
- Miss with empty FIFO: `mem_req` rises 1 cycle after `stb`. `rdy` returns to 1 in the cycle after `mem_ack`.
- `mem_ack` may arrive in the first cycle of `mem_req` (zero wait). `mem_req` drops in the cycle after the ack. A new request may start in that same cycle.
- `wr_ovf` is cleared only by reset.

## Test plan
- Write 0x5A to 0x1234, then read 0x1234. Required: `mem_we` request at 0x1234/0x5A, then a read request. `rdy` stays low until ack. `db_in` = 0x5A after re-presentation.
- Read 0x2000 with memory returning 0x77 after 3 cycles. Required: `mem_req` asserted for 4 cycles, `rdy` low during them, hold register valid. The repeated strobe at 0x2000 issues no new request and gives `db_in` = 0x77.
- Post 4 writes with `mem_ack` held low, then a 5th write. Required: the 5th write is dropped and `wr_ovf` = 1. The 4 writes complete in order once acks resume.
- Queue 2 writes, then read an address that is not pending. Required: FSM sits in DRAIN until both acks arrive, and the read request follows only after the FIFO is empty.
- Change the read address from 0x3000 to 0x4000 during RD_REQ. Required: 0x3000 data is discarded, a new request is issued at 0x4000, and `db_in` shows the 0x4000 data.
- Assert `rst` = 0 during an outstanding write request. Required: the next cycle has `mem_req` = 0, FIFO empty, `rdy` = 1, `db_in` = 0.
